// File: rtl/pick_pkg.sv
// Shared definitions for the pulse-picker trigger sequencer.
package pick_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_FIRE    = 3'd2,
    S_GAP     = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned INIT_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser for picker-domain signals into the system clock.
module sync_bit
  import pick_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pick_sequencer.sv
// Burst initiator for the pulse-picker 4-phase trigger handshake, with
// per-phase timeout, init-line recovery and shot statistics.
module pick_sequencer
  import pick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             wClk_i,
  input  logic             wReset_i,
  input  logic             wStart_i,
  input  logic             wAbort_i,
  input  logic [CNT_W-1:0] wCount_i,
  input  logic [CNT_W-1:0] wSpacing_i,
  input  logic [CNT_W-1:0] wTimeout_i,
  input  logic [7:0]       wDelay_i,
  input  logic [7:0]       wWidth_i,
  input  logic             wReady_i,
  output logic             wTrig_o,
  output logic [7:0]       wDelay_o,
  output logic [7:0]       wWidth_o,
  output logic             wInit_o,
  output logic             wBusy_o,
  output logic             wDone_o,
  output logic [CNT_W-1:0] wShots_o,
  output logic [CNT_W-1:0] wMissed_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d, spacing_q, spacing_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] shots_q, shots_d, missed_q, missed_d;
  logic [7:0]       delay_q, delay_d, width_q, width_d;
  logic             abort_q, abort_d;
  logic             trig_q, trig_d, init_q, init_d, busy_q, busy_d, done_q, done_d;
  logic             rdy;
  logic             timeout_hit;

  sync_bit #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk_i (wClk_i),
    .rst_i (wReset_i),
    .d_i   (wReady_i),
    .q_o   (rdy)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Where to go once a shot has either completed or been given up on.
  function automatic state_e attempt_end(input logic [CNT_W-1:0] shots,
                                         input logic [CNT_W-1:0] missed,
                                         input logic [CNT_W-1:0] count,
                                         input logic [CNT_W-1:0] spacing);
    logic [CNT_W:0] attempts;
    attempts = {1'b0, shots} + {1'b0, missed};
    if ((count != '0) && (attempts == {1'b0, count})) return S_IDLE;
    else if (spacing == '0)                            return S_ARM;
    else                                               return S_GAP;
  endfunction

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    count_d   = count_q;
    spacing_d = spacing_q;
    timeout_d = timeout_q;
    delay_d   = delay_q;
    width_d   = width_q;
    shots_d   = shots_q;
    missed_d  = missed_q;

    timeout_hit = (timeout_q != '0) && ((timer_q + CNT_W'(1)) == timeout_q);

    case (state_q)
      S_IDLE: begin
        if (wStart_i) begin
          state_d   = S_ARM;
          abort_d   = 1'b0;
          count_d   = wCount_i;
          spacing_d = wSpacing_i;
          timeout_d = wTimeout_i;
          delay_d   = wDelay_i;
          width_d   = wWidth_i;
          shots_d   = '0;
          missed_d  = '0;
        end
      end
      S_ARM: begin
        if (wAbort_i) begin
          state_d = S_RECOVER;
          abort_d = 1'b1;
        end else if (!rdy) begin
          state_d = S_FIRE;
        end else if (timeout_hit) begin
          state_d  = S_RECOVER;
          missed_d = sat_inc(missed_q);
        end
      end
      S_FIRE: begin
        if (wAbort_i) begin
          state_d = S_RECOVER;
          abort_d = 1'b1;
        end else if (rdy) begin
          shots_d = sat_inc(shots_q);
          state_d = attempt_end(shots_d, missed_q, count_q, spacing_q);
        end else if (timeout_hit) begin
          state_d  = S_RECOVER;
          missed_d = sat_inc(missed_q);
        end
      end
      S_GAP: begin
        if (wAbort_i) begin
          state_d = S_RECOVER;
          abort_d = 1'b1;
        end else if (timer_q == (spacing_q - CNT_W'(1))) begin
          state_d = S_ARM;
        end
      end
      S_RECOVER: begin
        if (timer_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = abort_q ? S_IDLE : attempt_end(shots_q, missed_q, count_q, spacing_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One timer serves phase timeout, gap spacing and init hold; it restarts on every state change.
    timer_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : timer_q + CNT_W'(1);

    trig_d = (state_d == S_ARM);
    init_d = (state_d == S_RECOVER);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge wClk_i) begin
    if (wReset_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      abort_q   <= 1'b0;
      count_q   <= '0;
      spacing_q <= '0;
      timeout_q <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      shots_q   <= '0;
      missed_q  <= '0;
      trig_q    <= 1'b0;
      init_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      abort_q   <= abort_d;
      count_q   <= count_d;
      spacing_q <= spacing_d;
      timeout_q <= timeout_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      shots_q   <= shots_d;
      missed_q  <= missed_d;
      trig_q    <= trig_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wTrig_o   = trig_q;
  assign wDelay_o  = delay_q;
  assign wWidth_o  = width_q;
  assign wInit_o   = init_q;
  assign wBusy_o   = busy_q;
  assign wDone_o   = done_q;
  assign wShots_o  = shots_q;
  assign wMissed_o = missed_q;

endmodule

// File: doc/pick_sequencer.md
Name: pick_sequencer

Overview:
- Initiator for the pulse-picker trigger handshake.
- Issues a programmed burst of pick requests (trigger, delay, width) and waits on the picker's ready flag for each shot.
- Detects lost shots by timeout, recovers the picker via its init line, and counts completed and missed shots for host readout.
- Sits between the host register block and the pulse picker.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising wReady_i (the picker runs on the pulse-derived clock).
- INIT_CYCLES, 4, number of cycles wInit_o is held high during recovery.
- CNT_W, 16, width of the count, spacing, timeout and statistics fields.

Ports:
- wClk_i  in  1  system clock; single clock domain for this block.
- wReset_i  in  1  synchronous, active-high reset.
- wStart_i  in  1  one-cycle start request; honoured only in S_IDLE.
- wAbort_i  in  1  level; terminates the burst from any non-idle state.
- wCount_i  in  CNT_W  shots per burst; 0 = continuous until abort.
- wSpacing_i  in  CNT_W  idle cycles between shot completion and the next trigger.
- wTimeout_i  in  CNT_W  per-phase timeout in cycles; 0 disables the timeout.
- wDelay_i  in  8  picker delay; latched at start.
- wWidth_i  in  8  picker width; latched at start.
- wReady_i  in  1  picker ready (high = picker idle); asynchronous to wClk_i.
- wTrig_o  out  1  trigger level to the picker.
- wDelay_o  out  8  latched delay; stable for the whole burst.
- wWidth_o  out  8  latched width; stable for the whole burst.
- wInit_o  out  1  picker re-initialisation.
- wBusy_o  out  1  high in every state except S_IDLE.
- wDone_o  out  1  one-cycle pulse when a burst ends.
- wShots_o  out  CNT_W  completed shots in the current or last burst.
- wMissed_o  out  CNT_W  timed-out shots in the current or last burst.

Behaviour:
- Reset: every output is 0, the state is S_IDLE, and the synchroniser and all counters are cleared. Reset applied mid-burst abandons the burst immediately, with no done pulse and no init pulse.
- rdy denotes wReady_i after the SYNC_STAGES synchroniser. rdy lags wReady_i by SYNC_STAGES cycles.
- States: S_IDLE, S_ARM, S_FIRE, S_GAP, S_RECOVER.
- S_IDLE, on wStart_i:
  - latch delay, width, count, spacing and timeout;
  - clear wShots_o and wMissed_o;
  - next cycle: S_ARM with wTrig_o=1.
- S_ARM:
  - wTrig_o is held at 1;
  - when rdy==0 (picker has accepted the trigger): go to S_FIRE and drive wTrig_o=0.
- S_FIRE:
  - wTrig_o=0;
  - when rdy==1 (pick complete): increment wShots_o, then apply the end-of-attempt rule below.
- Timeout:
  - one phase counter is cleared on every entry to S_ARM or S_FIRE and increments each cycle spent in those states;
  - when it equals the timeout value (nonzero), go to S_RECOVER, drive wTrig_o=0 and increment wMissed_o.
- S_RECOVER:
  - wInit_o=1 for exactly INIT_CYCLES cycles;
  - then apply the end-of-attempt rule, or go to S_IDLE if the state was entered via abort.
- End-of-attempt rule, where attempts = wShots_o + wMissed_o:
  - if count!=0 and attempts==count: go to S_IDLE and pulse wDone_o;
  - else if spacing==0: go directly to S_ARM (wTrig_o=1 next cycle);
  - else: go to S_GAP.
- S_GAP: counts spacing cycles, then goes to S_ARM.
- Abort:
  - wAbort_i high in S_ARM, S_FIRE or S_GAP: go to S_RECOVER with wTrig_o=0; no miss is counted.
  - On exit from S_RECOVER: go to S_IDLE and pulse wDone_o.
  - wAbort_i high in S_RECOVER: ignored; the sequence completes.
  - Abort takes priority over the rdy and timeout events in the same cycle.
- wStart_i while busy: ignored.
- Simultaneous rdy change and timeout expiry in the same cycle: the rdy event wins.
- Statistics counters saturate at all-ones. Continuous mode keeps running after saturation.
- wDone_o coincides with the cycle in which the state returns to S_IDLE. wShots_o and wMissed_o hold their values until the next start.
- The trigger is a 4-phase handshake (trig up, ready down, trig down, ready up). This guarantees the picker sees a clean rising edge regardless of its clock.

Decomposition:
- Shared package pick_pkg holds:
  - state encoding localparams S_IDLE..S_RECOVER;
  - default SYNC_STAGES and INIT_CYCLES.
- One sub-module, sync_bit: a parameterised SYNC_STAGES flop chain with reset to 0. It is also reusable for other picker-to-system signals.

Test Plan:
- Behavioural picker model with ready drop 3 cycles after trig and ready return 10 cycles later; count=3, spacing=2, timeout=0 -> three trig pulses, wShots_o=3, wMissed_o=0, a single wDone_o, and wDelay_o/wWidth_o equal to the values at start throughout.
- Model never drops ready; count=2, timeout=20 -> each trig stays high 20 cycles, then wInit_o high 4 cycles; wMissed_o=2, wShots_o=0, wDone_o pulses once.
- count=0, spacing=0; wAbort_i pulsed after 5 completed shots, during S_FIRE -> wTrig_o low, 4-cycle wInit_o, then wDone_o; wShots_o=5, wMissed_o=0.
- Second wStart_i issued in S_GAP -> ignored; shot total unchanged at count=4.
- wReset_i asserted in S_ARM with wTrig_o=1 -> next cycle all outputs 0, state idle, no wDone_o; a fresh start then runs normally.
- Timeout expiry in the same cycle rdy falls in S_ARM -> transition to S_FIRE, no miss counted.
